// File: rtl/rx_byte_fifo.sv
// Receive-side FWFT byte FIFO behind the UART receiver: edge-detected capture, fill level, sticky overflow.
// Build option RX_FIFO_DROP_ERR_EN: discard parity-errored characters instead of storing them.
module rx_byte_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    rx_data_in,
  input  logic                     rx_error_in,
  input  logic                     rx_valid_in,
  input  logic                     rd_en,
  input  logic                     clear_overflow,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_error,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef RX_FIFO_DROP_ERR_EN
  localparam int ENTRY_W = DATA_WIDTH;
`else
  localparam int ENTRY_W = DATA_WIDTH + 1;
`endif

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               valid_d;
  logic               wr_stb;
  logic               wr_ok;
  logic               do_wr;
  logic               do_rd;
  logic               ovf_set;

  // valid_d resets high so a level held through reset release is not seen as an edge
  assign wr_stb = rx_valid_in & ~valid_d;

`ifdef RX_FIFO_DROP_ERR_EN
  assign wr_ok    = wr_stb & ~rx_error_in;
  assign wr_entry = rx_data_in;
  assign rd_error = 1'b0;
`else
  assign wr_ok    = wr_stb;
  assign wr_entry = {rx_error_in, rx_data_in};
  assign rd_error = ~empty & head[DATA_WIDTH];
`endif

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  // a pop in the same cycle frees the slot, so a write into a full FIFO is still accepted
  assign do_wr   = wr_ok & (~full | do_rd);
  assign ovf_set = wr_ok & full & ~rd_en;

  assign head    = mem[rd_ptr];
  assign rd_data = empty ? '0 : head[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      valid_d  <= 1'b1;
    end else begin
      valid_d <= rx_valid_in;
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (do_rd && !do_wr) count <= count - 1'b1;
      if (ovf_set)             overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed self-checking bench for rx_byte_fifo (DEPTH 16); expected values are hand-computed constants.
module tb_rx_byte_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data_in;
  logic       rx_error_in;
  logic       rx_valid_in;
  logic       rd_en;
  logic       clear_overflow;
  logic [7:0] rd_data;
  logic       rd_error;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  rx_byte_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .rx_data_in(rx_data_in), .rx_error_in(rx_error_in),
    .rx_valid_in(rx_valid_in), .rd_en(rd_en), .clear_overflow(clear_overflow),
    .rd_data(rd_data), .rd_error(rd_error), .empty(empty), .full(full),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic e);
    rx_data_in  = d;
    rx_error_in = e;
    rx_valid_in = 1'b1;
    tick();
    rx_valid_in = 1'b0;
    tick();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0; rx_data_in = '0; rx_error_in = 1'b0; rx_valid_in = 1'b1;
    rd_en = 1'b0; clear_overflow = 1'b0;
    #3;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_error", rd_error, 0);
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_empty", empty, 1);
      chk("hold_count", count, 0);
    end
    rx_valid_in = 1'b0;
    tick();

    push(8'hA5, 1'b0);
    push(8'h3C, 1'b1);
`ifdef RX_FIFO_DROP_ERR_EN
    chk("two_count", count, 1);
    chk("two_head", rd_data, 8'hA5);
    chk("two_err", rd_error, 0);
    pop();
    chk("after_pop_empty", empty, 1);
    chk("after_pop_data", rd_data, 0);
`else
    chk("two_count", count, 2);
    chk("two_head", rd_data, 8'hA5);
    chk("two_err", rd_error, 0);
    pop();
    chk("second_data", rd_data, 8'h3C);
    chk("second_err", rd_error, 1);
    chk("second_count", count, 1);
    pop();
    chk("drained_empty", empty, 1);
    chk("drained_data", rd_data, 0);
    chk("drained_err", rd_error, 0);
`endif

    pop();
    chk("pop_empty_count", count, 0);

    rx_data_in = 8'h11; rx_error_in = 1'b0; rx_valid_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rx_valid_in = 1'b0;
    tick();
    chk("level_count", count, 1);
    chk("level_data", rd_data, 8'h11);
    pop();
    chk("level_empty", empty, 1);

    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_ovf", overflow, 0);
    push(8'hFF, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      chk("drain1_data", rd_data, i);
      pop();
    end
    chk("drain1_empty", empty, 1);
    chk("drain1_ovf_sticky", overflow, 1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("ovf_cleared", overflow, 0);

    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 1'b0);
    chk("fill2_full", full, 1);
    rx_data_in = 8'h77; rx_valid_in = 1'b1; rd_en = 1'b1;
    tick();
    rx_valid_in = 1'b0; rd_en = 1'b0;
    tick();
    chk("wr_rd_full_ovf", overflow, 0);
    chk("wr_rd_full_count", count, 16);
    chk("wr_rd_full_head", rd_data, 8'h21);
    for (int i = 1; i < 16; i++) begin
      chk("drain2_data", rd_data, 8'h20 + 8'(i));
      pop();
    end
    chk("drain2_last", rd_data, 8'h77);
    pop();
    chk("drain2_empty", empty, 1);

    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i), 1'b0);
    push(8'hFF, 1'b0);
    for (int i = 0; i < 11; i++) pop();
    chk("pre_rst_count", count, 5);
    chk("pre_rst_ovf", overflow, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_data", rd_data, 0);
    tick();
    reset = 1'b1;
    tick();

    rx_data_in = 8'h5A; rx_error_in = 1'b0; rx_valid_in = 1'b1; rd_en = 1'b1;
    tick();
    rx_valid_in = 1'b0; rd_en = 1'b0;
    tick();
    chk("wr_rd_empty_count", count, 1);
    chk("wr_rd_empty_data", rd_data, 8'h5A);
    for (int i = 1; i < 16; i++) push(8'(i), 1'b0);
    chk("fill3_full", full, 1);
    rx_data_in = 8'hEE; rx_valid_in = 1'b1; clear_overflow = 1'b1;
    tick();
    rx_valid_in = 1'b0; clear_overflow = 1'b0;
    tick();
    chk("set_beats_clear", overflow, 1);
    chk("fill3_count", count, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_byte_fifo.md
# rx_byte_fifo

Receive-side buffer that sits directly downstream of the UART receiver top. It captures each received character and its parity-error flag on the rising edge of the receiver's valid indication, and stores them in a DEPTH-entry circular FIFO. It presents the oldest entry to the host in first-word-fall-through form, and reports fill level plus a sticky overflow flag.

## Interface
- `DATA_WIDTH`, 8, character width; matches the receiver's data width.
- `DEPTH`, 16, number of entries; power of two, at least 2.
- `clk`  input  1  system clock; all logic samples on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `rx_data_in`  input  DATA_WIDTH  received character from the UART receiver.
- `rx_error_in`  input  1  parity error flag for the character on `rx_data_in`.
- `rx_valid_in`  input  1  receiver data-valid; may be a pulse or a level; only its rising edge is used.
- `rd_en`  input  1  pop request; pops the head entry when not empty.
- `clear_overflow`  input  1  synchronous clear of `overflow`.
- `rd_data`  output  DATA_WIDTH  head-of-FIFO character; 0 when empty.
- `rd_error`  output  1  error flag of the head entry; 0 when empty.
- `empty`  output  1  FIFO holds no entries.
- `full`  output  1  FIFO holds DEPTH entries.
- `count`  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- `overflow`  output  1  sticky: a character was dropped because the FIFO was full.

## Operation
- Edge detect: `valid_d` is a register of `rx_valid_in`. Write strobe `wr_stb = rx_valid_in & ~valid_d`.
- `valid_d` resets to 1, so a `rx_valid_in` held high through reset release does not cause a spurious write.
- Storage: DEPTH × (DATA_WIDTH+1) array holding {error, data}. Storage is not reset.
- Pointers: write and read pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- `count` is an explicit counter. `full = (count == DEPTH)`, `empty = (count == 0)`; both are registered-equivalent and glitch-free.
- Write: when `wr_stb` is high and the FIFO is not full, store the entry at the write pointer and increment the write pointer.
- Read: when `rd_en` is high and the FIFO is not empty, increment the read pointer. A read while empty is ignored and has no side effects.
- Simultaneous write and read with the FIFO non-empty, including full: both occur, `count` is unchanged, and no overflow is raised.
- Simultaneous write and read while empty: the write is accepted and the read is ignored; `count` becomes 1.
- Overflow: when `wr_stb` is high while full and `rd_en` is low, the character is dropped and `overflow` is set. It stays set until `clear_overflow`. If set and clear occur in the same cycle, set wins.
- `count` arithmetic: +1 on write only, −1 on read only, otherwise hold. It never exceeds DEPTH and never goes below 0.

## Timing
- Reset (asynchronous assert, any cycle including mid-transfer) drives:
  - pointers 0, `count` 0, `empty` 1, `full` 0, `overflow` 0;
  - `rd_data` 0, `rd_error` 0, `valid_d` 1.
- Write latency: on a `wr_stb` at edge N, the entry is stored at edge N. From the cycle after N, `empty` is 0, `count` is incremented, and `rd_data`/`rd_error` show the head entry.
- Read: `rd_data` is valid in the same cycle `rd_en` is asserted. The next entry, or 0 if the FIFO became empty, appears the cycle after the pop edge.
- A `rx_valid_in` level held for multiple cycles produces exactly one write. A new write needs `rx_valid_in` to go low for at least one cycle and then high again.
- Back-to-back writes at one per two cycles are accepted indefinitely while the host drains at the same rate.

## Configuration
- Macro `RX_FIFO_DROP_ERR_EN`.
  - Defined: a strobe with `rx_error_in = 1` is discarded. It changes no pointer or count and never sets `overflow`. `rd_error` is tied to 0.
  - Not defined: errored characters are stored with their error bit and presented on `rd_error`.

## Test plan
- Reset release with `rx_valid_in` held high: `empty` = 1 and `count` = 0 for 10 cycles; no write occurs.
- Write 0xA5 (error 0) and then 0x3C (error 1), each as a 1-cycle `rx_valid_in` pulse:
  - `count` = 2 and `rd_data` = 0xA5, `rd_error` = 0;
  - after one `rd_en`: `rd_data` = 0x3C, `rd_error` = 1 (without the macro); with the macro, `count` = 1 and 0x3C is never seen.
- Hold `rx_valid_in` high for 5 cycles with data 0x11: exactly one entry is stored, `count` = 1.
- Fill with 0x00..0x0F (DEPTH = 16): `full` = 1. A 17th write 0xFF sets `overflow` and `count` stays 16. Draining returns 0x00..0x0F in order, and pointers wrap correctly on a second fill.
- Full FIFO plus write 0x77 with `rd_en` in the same cycle: `overflow` stays 0, `count` stays 16, and 0x77 is returned last.
- Assert `reset` while `count` = 5: `count` = 0, `empty` = 1, `overflow` = 0 immediately. A `clear_overflow` coinciding with a new overflow leaves `overflow` = 1.
